module_bintobcd_seq: RTL and testbench

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It converts an arbitrary-width unsigned word into `DIGITS` packed BCD digits and adds valid/ready handshakes on input and output, plus overflow detection. It sits between the arithmetic datapath and the 7-segment display driver, and supersedes the fixed 4-bit combinational converter for multi-digit results.

---
 rtl/bintobcd_pkg.sv | 18 +
 rtl/module_bcd_add3.sv | 17 +
 rtl/module_bintobcd_seq.sv | 137 +++++++++++++
 tb/tb_module_bintobcd_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bintobcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and bit-counter sizing.
package bintobcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    // Counter must hold WIDTH_IN itself, hence the +1.
    function automatic int cnt_width(input int width_in);
        return $clog2(width_in + 1);
    endfunction

endpackage

// File: rtl/module_bcd_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module module_bcd_add3
    import bintobcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] corrected
);

    // Add-3 correction for digits 5..15
    always_comb begin
        corrected = digit;
        if (digit >= BCD_DIGIT_W'(5))
            corrected = digit + BCD_DIGIT_W'(3);
    end

endmodule

// File: rtl/module_bintobcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on both sides and sticky overflow detection.
// Optional macro BINTOBCD_BLANK_EN adds the registered leading-zero mask blank_o.
module module_bintobcd_seq
    import bintobcd_pkg::*;
#(
    parameter int WIDTH_IN = 14,
    parameter int DIGITS   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH_IN-1:0]           bin_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          overflow_o
`ifdef BINTOBCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]             blank_o
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(WIDTH_IN);

    bcd_state_t          state;
    bcd_state_t          next_state;
    logic [WIDTH_IN-1:0] bin_reg;
    logic [BCD_W-1:0]    bcd_reg;
    logic [BCD_W-1:0]    corr;
    logic [BCD_W-1:0]    shifted_bcd;
    logic                ovf;
    logic [CNT_W-1:0]    cnt;
    logic                last_shift;

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        module_bcd_add3 u_add3 (
            .digit     (bcd_reg[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .corrected (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected BCD shifted left with the binary MSB entering digit 0;
    // the bit leaving the top digit goes to the overflow flag instead.
    assign shifted_bcd = {corr[BCD_W-2:0], bin_reg[WIDTH_IN-1]};
    assign last_shift  = (state == SHIFT) && (cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: accept in IDLE, count bits in SHIFT, release in DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid_i)    next_state = SHIFT;
            SHIFT:   if (last_shift) next_state = DONE;
            DONE:    if (ready_i)    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control and result registers: clear on accept, shift-and-add during SHIFT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_reg <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        bcd_reg <= '0;
                        ovf     <= 1'b0;
                        cnt     <= CNT_W'(WIDTH_IN);
                    end
                end
                SHIFT: begin
                    bcd_reg <= shifted_bcd;
                    ovf     <= ovf | corr[BCD_W-1];
                    cnt     <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Binary shift register: pure data, loaded only on the input handshake
    always_ff @(posedge clk) begin
        if (state == IDLE && valid_i)
            bin_reg <= bin_i;
        else if (state == SHIFT)
            bin_reg <= bin_reg << 1;
    end

    assign ready_o    = (state == IDLE);
    assign valid_o    = (state == DONE);
    assign bcd_o      = bcd_reg;
    assign overflow_o = ovf;

`ifdef BINTOBCD_BLANK_EN
    // Bit 0 never blanks so that a zero result still shows one "0".
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_next;
    logic              zero_run;
    logic [DIGITS-1:0] blank_reg;

    // Leading-zero mask of the final BCD value, scanned from the top digit down
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (shifted_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_next[i] = zero_run;
        end
    end

    // Mask captured on the SHIFT->DONE edge and held until the next result
    always_ff @(posedge clk) begin
        if (!rst_n)
            blank_reg <= BLANK_RST;
        else if (last_shift)
            blank_reg <= blank_next;
    end

    assign blank_o = blank_reg;
`endif

endmodule

// File: tb/tb_module_bintobcd_seq.sv
// Directed bench for module_bintobcd_seq (WIDTH_IN=14, DIGITS=4).
module tb_module_bintobcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [13:0] bin_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] bcd_o;
    logic        overflow_o;
`ifdef BINTOBCD_BLANK_EN
    logic [3:0]  blank_o;
`endif

    int total = 0;
    int bad   = 0;

    module_bintobcd_seq #(.WIDTH_IN(14), .DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .bin_i      (bin_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .bcd_o      (bcd_o),
        .overflow_o (overflow_o)
`ifdef BINTOBCD_BLANK_EN
        ,
        .blank_o    (blank_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits of v mod 10000 by division
    function automatic logic [15:0] exp_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v % 10000;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_blank(input int v);
        logic [3:0] r;
        int t;
        t = v % 10000;
        r[0] = 1'b0;
        r[1] = (t < 10);
        r[2] = (t < 100);
        r[3] = (t < 1000);
        return r;
    endfunction

    // Wait for ready_o (bounded), hand over v, then count cycles to valid_o
    task automatic start(input int v, output int lat);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        valid_i = 1'b1;
        bin_i   = 14'(v);
        tick();
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
        end
        total++;
        if (bcd_o !== 16'h0000 || overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_data bcd_o=%h ovf=%b required 0000/0", bcd_o, overflow_o);
        end
`ifdef BINTOBCD_BLANK_EN
        total++;
        if (blank_o !== 4'b1110) begin
            bad++;
            $display("FAIL reset_blank blank_o=%b required 1110", blank_o);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_9999();
        int lat;
        start(9999, lat);
        total++;
        if (lat !== 14) begin
            bad++;
            $display("FAIL latency_9999 got=%0d required=14", lat);
        end
        total++;
        if (bcd_o !== 16'h9999 || overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL value_9999 bcd_o=%h ovf=%b required 9999/0", bcd_o, overflow_o);
        end
        release_result();
    endtask

    task automatic test_zero();
        int lat;
        start(0, lat);
        total++;
        if (valid_o !== 1'b1 || bcd_o !== 16'h0000 || overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL value_0 valid=%b bcd_o=%h ovf=%b required 1/0000/0", valid_o, bcd_o, overflow_o);
        end
`ifdef BINTOBCD_BLANK_EN
        total++;
        if (blank_o !== 4'b1110) begin
            bad++;
            $display("FAIL blank_0 blank_o=%b required 1110", blank_o);
        end
`endif
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        start(12345, lat);
        total++;
        if (bcd_o !== 16'h2345 || overflow_o !== 1'b1) begin
            bad++;
            $display("FAIL value_12345 bcd_o=%h ovf=%b required 2345/1", bcd_o, overflow_o);
        end
        release_result();
    endtask

    task automatic test_stall();
        int lat;
        start(42, lat);
        for (int c = 0; c < 5; c++) begin
            valid_i = c[0];
            bin_i   = 14'd999;
            tick();
            total++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || bcd_o !== 16'h0042 || overflow_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d valid=%b ready=%b bcd_o=%h ovf=%b required 1/0/0042/0",
                         c, valid_o, ready_o, bcd_o, overflow_o);
            end
`ifdef BINTOBCD_BLANK_EN
            total++;
            if (blank_o !== 4'b1100) begin
                bad++;
                $display("FAIL stall_blank cyc=%0d blank_o=%b required 1100", c, blank_o);
            end
`endif
        end
        valid_i = 1'b0;
        release_result();
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_release valid=%b ready=%b required 0/1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        valid_i = 1'b1;
        bin_i   = 14'd5000;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || bcd_o !== 16'h0000) begin
            bad++;
            $display("FAIL midreset ready=%b valid=%b bcd_o=%h required 1/0/0000", ready_o, valid_o, bcd_o);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid_o) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_lost valid_cycles=%0d required=0", seen);
        end
        start(7, lat);
        total++;
        if (lat !== 14 || bcd_o !== 16'h0007 || overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_7 lat=%0d bcd_o=%h ovf=%b required 14/0007/0", lat, bcd_o, overflow_o);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] got;
        got     = 16'hxxxx;
        ready_i = 1'b1;
        valid_i = 1'b1;
        bin_i   = 14'd123;
        tick();
        n = 0;
        while (!ready_o && n < 40) begin
            tick();
            n++;
            if (valid_o) got = bcd_o;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        total++;
        if (n !== 15 || got !== 16'h0123) begin
            bad++;
            $display("FAIL back_to_back cycles=%0d bcd=%h required 15/0123", n, got);
        end
        tick();
    endtask

    task automatic check_one(input int v);
        int lat;
        start(v, lat);
        for (int s = 0; s < int'($urandom_range(0, 2)); s++) tick();
        total++;
        if (lat !== 14 || valid_o !== 1'b1 || bcd_o !== exp_bcd(v) || overflow_o !== (v > 9999)) begin
            bad++;
            $display("FAIL sweep v=%0d lat=%0d valid=%b bcd_o=%h ovf=%b required 14/1/%h/%b",
                     v, lat, valid_o, bcd_o, overflow_o, exp_bcd(v), (v > 9999));
        end
`ifdef BINTOBCD_BLANK_EN
        total++;
        if (blank_o !== exp_blank(v)) begin
            bad++;
            $display("FAIL sweep_blank v=%0d blank_o=%b required %b", v, blank_o, exp_blank(v));
        end
`endif
        release_result();
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 1024; v += 3) check_one(v);
        for (int v = 9990; v <= 10010; v++) check_one(v);
        for (int v = 1024; v < 16384; v += 97) check_one(v);
        for (int v = 16375; v <= 16383; v++) check_one(v);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        bin_i   = '0;
        test_reset();
        test_9999();
        test_zero();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
